// File: rtl/video_tmds_enc.sv
// video_tmds_enc: three-channel TMDS encoder with DC balance and control tokens.
// Define VIDEO_TMDS_HDMI_EN to add the HDMI video preamble and leading guard band.
module video_tmds_ch #(
  parameter logic [9:0] GB = 10'b1011001100
) (
  input  logic       clk,
  input  logic       res_n,
  input  logic [7:0] d_i,
  input  logic       de_i,
  input  logic [1:0] c_i,
  input  logic       gb_i,
  output logic [9:0] q_o
);
  logic [3:0]        n1_a, n1_b;
  logic              xn, p, case_a, case_b, pos;
  logic [8:0]        qm_d, qm_q;
  logic              de_q, gb_q;
  logic [1:0]        c_q;
  logic [5:0]        diff, cnt6, sum;
  logic [4:0]        cnt_d, cnt_q;
  logic [9:0]        tok, sym_d, sym_q;

  always_comb begin
    n1_a = 4'd0;
    for (int i = 0; i < 8; i++) n1_a = n1_a + {3'd0, d_i[i]};
    xn = (n1_a > 4'd4) || (n1_a == 4'd4 && !d_i[0]);
    p = d_i[0];
    qm_d = 9'd0;
    qm_d[0] = p;
    // an xnor chain equals the xor prefix inverted on every odd bit
    for (int i = 1; i < 8; i++) begin
      p = p ^ d_i[i];
      qm_d[i] = p ^ ((i % 2 == 1) ? xn : 1'b0);
    end
    qm_d[8] = ~xn;
  end

  always_comb begin
    n1_b = 4'd0;
    for (int i = 0; i < 8; i++) n1_b = n1_b + {3'd0, qm_q[i]};
    diff = {1'b0, n1_b, 1'b0} - 6'd8;
    cnt6 = {cnt_q[4], cnt_q};
    pos = !cnt_q[4] && cnt_q != 5'd0;
    case_a = cnt_q == 5'd0 || n1_b == 4'd4;
    case_b = (pos && n1_b > 4'd4) || (cnt_q[4] && n1_b < 4'd4);
    sum = case_a ? (qm_q[8] ? cnt6 + diff : cnt6 - diff) :
          case_b ? cnt6 - diff + {4'd0, qm_q[8], 1'b0} :
                   cnt6 + diff - (qm_q[8] ? 6'd0 : 6'd2);
    tok = c_q == 2'b00 ? 10'b1101010100 :
          c_q == 2'b01 ? 10'b0010101011 :
          c_q == 2'b10 ? 10'b0101010100 : 10'b1010101011;
    sym_d = !de_q ? (gb_q ? GB : tok) :
            case_a ? {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]} :
            case_b ? {1'b1, qm_q[8], ~qm_q[7:0]} : {1'b0, qm_q[8], qm_q[7:0]};
    cnt_d = de_q ? sum[4:0] : 5'd0;
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      qm_q  <= 9'd0;
      de_q  <= 1'b0;
      gb_q  <= 1'b0;
      c_q   <= 2'b00;
      cnt_q <= 5'd0;
      sym_q <= 10'b1101010100;
    end else begin
      qm_q  <= qm_d;
      de_q  <= de_i;
      gb_q  <= gb_i;
      c_q   <= c_i;
      cnt_q <= cnt_d;
      sym_q <= sym_d;
    end
  end

  assign q_o = sym_q;
endmodule

module video_tmds_enc (
  input  logic       clk,
  input  logic       res_n,
  input  logic [7:0] vred,
  input  logic [7:0] vgrn,
  input  logic [7:0] vblu,
  input  logic       hsync,
  input  logic       vsync,
  input  logic       vga_blank,
  output logic [9:0] tmds_r,
  output logic [9:0] tmds_g,
  output logic [9:0] tmds_b
);
  logic       de, hs, vs, gb;
  logic [1:0] c1;
  logic [7:0] r, g, b;
`ifdef VIDEO_TMDS_HDMI_EN
  logic [26:0] sr_q [10];
  logic [3:0]  run_d, run_q, ph_d, ph_q;
  logic        trig;

  // a pixel arriving after a long blank run tags the ten blanks ahead of it
  always_comb begin
    trig  = !vga_blank && run_q == 4'd12;
    run_d = !vga_blank ? 4'd0 : (run_q == 4'd12 ? 4'd12 : run_q + 4'd1);
    ph_d  = trig ? 4'd1 : (ph_q != 4'd0 && ph_q != 4'd10) ? ph_q + 4'd1 : 4'd0;
    {de, vs, hs, r, g, b} = sr_q[9];
    gb = ph_d > 4'd8;
    c1 = (ph_d != 4'd0 && ph_d < 4'd9) ? 2'b01 : 2'b00;
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      for (int i = 0; i < 10; i++) sr_q[i] <= 27'd0;
      run_q <= 4'd0;
      ph_q  <= 4'd0;
    end else begin
      sr_q[0] <= {~vga_blank, vsync, hsync, vred, vgrn, vblu};
      for (int i = 1; i < 10; i++) sr_q[i] <= sr_q[i-1];
      run_q <= run_d;
      ph_q  <= ph_d;
    end
  end
`else
  always_comb begin
    {de, vs, hs, r, g, b} = {~vga_blank, vsync, hsync, vred, vgrn, vblu};
    gb = 1'b0;
    c1 = 2'b00;
  end
`endif

  video_tmds_ch #(.GB(10'b1011001100)) u_ch0 (
    .clk(clk), .res_n(res_n), .d_i(b), .de_i(de), .c_i({vs, hs}), .gb_i(gb), .q_o(tmds_b)
  );
  video_tmds_ch #(.GB(10'b0100110011)) u_ch1 (
    .clk(clk), .res_n(res_n), .d_i(g), .de_i(de), .c_i(c1), .gb_i(gb), .q_o(tmds_g)
  );
  video_tmds_ch #(.GB(10'b1011001100)) u_ch2 (
    .clk(clk), .res_n(res_n), .d_i(r), .de_i(de), .c_i(2'b00), .gb_i(gb), .q_o(tmds_r)
  );
endmodule

// File: tb/tb_video_tmds_enc.sv
// tb_video_tmds_enc: scoreboard bench for video_tmds_enc with directed vectors.
module tb_video_tmds_enc;
  logic       clk = 1'b0;
  logic       res_n = 1'b0;
  logic [7:0] vred = 8'd0, vgrn = 8'd0, vblu = 8'd0;
  logic       hsync = 1'b0, vsync = 1'b0, vga_blank = 1'b1;
  logic [9:0] tmds_r, tmds_g, tmds_b;

  localparam logic [9:0] T0 = 10'b1101010100, T1 = 10'b0010101011;
  localparam logic [9:0] T2 = 10'b0101010100, T3 = 10'b1010101011;
  localparam logic [9:0] Z0 = 10'b0100000000, ON = 10'b1111111111;
  localparam logic [9:0] FA = 10'b1000000000, FC = 10'b0011111111;
  localparam logic [9:0] HA = 10'b0111110000;
`ifdef VIDEO_TMDS_HDMI_EN
  localparam int LAT = 12;
  localparam logic [9:0] GB0 = 10'b1011001100, GB1 = 10'b0100110011;
  int run = 0;
`else
  localparam int LAT = 2;
`endif

  typedef struct packed {
    logic [31:0] due;
    logic [9:0]  r, g, b;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   errors = 0, checks = 0;

  video_tmds_enc dut (
    .clk(clk), .res_n(res_n), .vred(vred), .vgrn(vgrn), .vblu(vblu),
    .hsync(hsync), .vsync(vsync), .vga_blank(vga_blank),
    .tmds_r(tmds_r), .tmds_g(tmds_g), .tmds_b(tmds_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].due < cyc) begin
      e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL late due=%0d cyc=%0d", e.due, cyc);
    end
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      checks++;
      if ({tmds_r, tmds_g, tmds_b} !== {e.r, e.g, e.b}) begin
        errors++;
        $display("FAIL sym cyc=%0d got r=%b g=%b b=%b want r=%b g=%b b=%b",
                 cyc, tmds_r, tmds_g, tmds_b, e.r, e.g, e.b);
      end
    end
  end

  task automatic chk_tok(input string name);
    checks++;
    if ({tmds_r, tmds_g, tmds_b} !== {T0, T0, T0}) begin
      errors++;
      $display("FAIL %s got r=%b g=%b b=%b want all %b", name, tmds_r, tmds_g, tmds_b, T0);
    end
  endtask

  task automatic px(input logic bl, input logic h, input logic v,
                    input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                    input logic [9:0] er, input logic [9:0] eg, input logic [9:0] eb);
    exp_t e;
    vga_blank = bl; hsync = h; vsync = v; vred = r; vgrn = g; vblu = b;
`ifdef VIDEO_TMDS_HDMI_EN
    if (!bl && run == 12)
      for (int k = 0; k < 10; k++) begin
        int idx;
        idx = q.size() - 10 + k;
        if (k < 8) q[idx].g = T1;
        else begin
          q[idx].r = GB0; q[idx].g = GB1; q[idx].b = GB0;
        end
      end
    run = bl ? (run == 12 ? 12 : run + 1) : 0;
`endif
    e.due = cyc + LAT; e.r = er; e.g = eg; e.b = eb;
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 4; k++) begin
      {vred, vgrn, vblu} = 24'($urandom);
      {hsync, vsync, vga_blank} = 3'($urandom);
      @(posedge clk); #1;
      chk_tok("reset_hold");
    end
    vga_blank = 1'b1; hsync = 1'b0; vsync = 1'b0; {vred, vgrn, vblu} = 24'd0;
    res_n = 1'b1;
    repeat (6) px(1, 0, 0, 8'h00, 8'h00, 8'h00, T0, T0, T0);
    repeat (2) px(1, 1, 0, 8'h00, 8'h00, 8'h00, T0, T0, T1);
    repeat (2) px(1, 0, 1, 8'h00, 8'h00, 8'h00, T0, T0, T2);
    repeat (2) px(1, 1, 1, 8'h00, 8'h00, 8'h00, T0, T0, T3);
    repeat (8) px(1, 0, 0, 8'h00, 8'h00, 8'h00, T0, T0, T0);
    px(0, 0, 0, 8'h00, 8'h00, 8'h00, Z0, Z0, Z0);
    px(0, 0, 0, 8'h00, 8'h00, 8'h00, ON, ON, ON);
    px(0, 0, 0, 8'h00, 8'h00, 8'h00, Z0, Z0, Z0);
    px(1, 0, 0, 8'h00, 8'h00, 8'h00, T0, T0, T0);
    px(0, 0, 0, 8'hFF, 8'h00, 8'h00, FA, Z0, Z0);
    px(0, 0, 0, 8'hFF, 8'h00, 8'h10, FC, ON, HA);
    px(0, 0, 0, 8'h00, 8'h00, 8'h00, ON, Z0, ON);
    px(0, 0, 0, 8'hFF, 8'hFF, 8'hFF, FA, FC, FA);
    repeat (6) px(1, 0, 0, 8'h00, 8'h00, 8'h00, T0, T0, T0);
    px(0, 0, 0, 8'h00, 8'h00, 8'h00, Z0, Z0, Z0);
    for (int k = 0; k < 2; k++) begin
      repeat (4) px(1, 0, 0, 8'h00, 8'h00, 8'h00, T0, T0, T0);
      px(0, 0, 0, 8'h00, 8'h00, 8'h00, Z0, Z0, Z0);
      px(0, 0, 0, 8'h00, 8'h00, 8'h00, ON, ON, ON);
      px(0, 0, 0, 8'h00, 8'h00, 8'h00, Z0, Z0, Z0);
      px(0, 0, 0, 8'h00, 8'h00, 8'h00, ON, ON, ON);
    end
    px(0, 0, 0, 8'hFF, 8'h00, 8'h00, FA, Z0, Z0);
    px(0, 0, 0, 8'hFF, 8'h00, 8'h00, FC, ON, ON);
    #2 res_n = 1'b0;
    #1 chk_tok("reset_async");
    q.delete();
`ifdef VIDEO_TMDS_HDMI_EN
    run = 0;
`endif
    @(posedge clk); #1;
    chk_tok("reset_mid");
    res_n = 1'b1;
    repeat (3) px(1, 0, 0, 8'h00, 8'h00, 8'h00, T0, T0, T0);
    px(0, 0, 0, 8'h00, 8'h00, 8'h00, Z0, Z0, Z0);
    repeat (2) px(1, 0, 0, 8'h00, 8'h00, 8'h00, T0, T0, T0);
    vga_blank = 1'b1;
    for (int k = 0; k < LAT + 4 && q.size() > 0; k++) @(posedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
